// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier family: default operand width and
// the common arbiter FSM state encoding.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/shift_add_core.sv
// Radix-2 shift-add signed multiplier core: latches operand magnitudes on
// i_start, runs one multiplier bit per cycle, pulses o_done with the result.
module shift_add_core
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_result;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_run;
  logic               r_done;

  // Negating the most negative value yields 2^(WIDTH-1), exact as unsigned.
  always_comb begin
    w_a_mag    = i_a[WIDTH-1] ? -i_a : i_a;
    w_b_mag    = i_b[WIDTH-1] ? -i_b : i_b;
    w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_last     = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_run    <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_run    <= 1'b0;
        r_done   <= 1'b1;
        r_result <= r_neg ? -w_acc_next : w_acc_next;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: rtl/mult_share_arbiter.sv
// Two-requester front end sharing one shift-add multiplier: round-robin
// grant, operand/response steering and the IDLE/RUN/DONE sequencing FSM.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [2*WIDTH-1:0] rsp0_result,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp1_result,
  output logic               busy,
  output logic               owner
);

  mult_state_e        r_state;
  mult_state_e        w_next;
  logic               r_last;
  logic               r_owner;
  logic               w_any;
  logic               w_grant;
  logic               w_accept;
  logic [WIDTH-1:0]   w_op_a;
  logic [WIDTH-1:0]   w_op_b;
  logic               w_core_done;
  logic [2*WIDTH-1:0] w_core_result;

  shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept),
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .o_done  (w_core_done),
    .o_result(w_core_result)
  );

  // rst_n gates ready so nothing looks accepted while reset is held.
  always_comb begin
    w_any    = req0_valid | req1_valid;
    w_grant  = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    w_accept = (r_state == ST_IDLE) & w_any & rst_n;
    w_op_a   = w_grant ? req1_a : req0_a;
    w_op_b   = w_grant ? req1_b : req0_b;
    w_next   = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_RUN;
      ST_RUN:  if (w_core_done) w_next = ST_DONE;
      ST_DONE: if (r_owner ? rsp1_ready : rsp0_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    req0_ready  = w_accept & ~w_grant;
    req1_ready  = w_accept & w_grant;
    rsp0_valid  = (r_state == ST_DONE) & ~r_owner;
    rsp1_valid  = (r_state == ST_DONE) & r_owner;
    rsp0_result = rsp0_valid ? w_core_result : '0;
    rsp1_result = rsp1_valid ? w_core_result : '0;
    busy        = (r_state != ST_IDLE);
    owner       = r_owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_grant;
        r_last  <= w_grant;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized self-checking bench for mult_share_arbiter against a
// behavioural product / round-robin reference model.
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [63:0] rsp0_result, rsp1_result;
  logic        busy, owner;

  int errors;
  int checks;
  bit last_served;

  mult_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      2:       return 32'h0;
      3:       return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic f_qready(input int n);
    return (n == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic f_svalid(input int n);
    return (n == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [63:0] f_sres(input int n);
    return (n == 0) ? rsp0_result : rsp1_result;
  endfunction

  task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin req0_valid = v; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; end
  endtask

  task automatic set_rsp_ready(input int n, input logic v);
    if (n == 0) rsp0_ready = v; else rsp1_ready = v;
  endtask

  // One transaction on requester n with response ready held high.
  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] res,
                       output bit timeout, output bit other_seen);
    int k;
    timeout = 0; other_seen = 0; lat = 0; res = '0;
    @(posedge clk); #1;
    set_req(n, 1'b1, a, b);
    set_rsp_ready(n, 1'b1);
    #1;
    for (k = 0; k < 10 && !f_qready(n); k++) begin
      @(posedge clk); #2;
    end
    if (k == 10) begin
      timeout = 1;
      set_req(n, 1'b0, '0, '0);
      set_rsp_ready(n, 1'b0);
      return;
    end
    @(posedge clk); #1;
    set_req(n, 1'b0, $urandom, $urandom);
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (f_svalid(1 - n)) other_seen = 1;
      if (f_svalid(n)) break;
      if (lat > 60) begin timeout = 1; break; end
    end
    res = f_sres(n);
    @(posedge clk); #1;
    set_rsp_ready(n, 1'b0);
  endtask

  // Both requesters valid at once; records accept order and results.
  task automatic serve_pair(input logic [31:0] a0, input logic [31:0] b0,
                            input logic [31:0] a1, input logic [31:0] b1,
                            output int first, output int second, output int first_cyc,
                            output logic [63:0] res0, output logic [63:0] res1,
                            output bit owner_bad, output bit timeout);
    int nacc, nrsp;
    logic acc0, acc1, hs0, hs1;
    first = -1; second = -1; first_cyc = -1; res0 = '0; res1 = '0;
    owner_bad = 0; nacc = 0; nrsp = 0;
    set_req(0, 1'b1, a0, b0);
    set_req(1, 1'b1, a1, b1);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 200 && nrsp < 2; cyc++) begin
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      hs0  = rsp0_valid & rsp0_ready;
      hs1  = rsp1_valid & rsp1_ready;
      if (hs0) begin res0 = rsp0_result; if (owner !== 1'b0) owner_bad = 1; nrsp++; end
      if (hs1) begin res1 = rsp1_result; if (owner !== 1'b1) owner_bad = 1; nrsp++; end
      if (acc0 || acc1) begin
        if (nacc == 0) begin first = acc1 ? 1 : 0; first_cyc = cyc; end
        else second = acc1 ? 1 : 0;
        nacc++;
      end
      @(posedge clk); #1;
      if (acc0) set_req(0, 1'b0, $urandom, $urandom);
      if (acc1) set_req(1, 1'b0, $urandom, $urandom);
      #1;
    end
    timeout = (nrsp < 2);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1'b1, 32'd5, 32'd6);
    set_req(1, 1'b1, 32'd7, 32'd8);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #3;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, owner} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, owner});
    end
    checks++;
    if ({rsp0_result, rsp1_result} !== 128'b0) begin
      errors++;
      $display("FAIL reset_result: got %h/%h expected 0/0", rsp0_result, rsp1_result);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    rst_n = 1'b1;
    last_served = 1;
  endtask

  task automatic test_single();
    int lat; logic [63:0] res; bit to, other;
    issue(0, 32'd15, 32'd10, lat, res, to, other);
    checks++;
    if (to || lat != 33) begin
      errors++;
      $display("FAIL single_latency: got %0d (timeout=%0d) expected 33", lat, to);
    end
    checks++;
    if (res !== 64'd150) begin
      errors++;
      $display("FAIL single_result: got %0d expected 150", $signed(res));
    end
    checks++;
    if (other) begin
      errors++;
      $display("FAIL single_other_rsp: got rsp1_valid high expected never");
    end
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got valid=%b busy=%b expected 0 0", rsp0_valid, busy);
    end
    last_served = 0;
  endtask

  task automatic test_tie();
    int f, s, fc; logic [63:0] r0, r1; bit ob, to;
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_req(0, 1'b1, -32'sd7, 32'sd14);
    set_req(1, 1'b1, 32'sd15, -32'sd10);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_served = 1;
    serve_pair(-32'sd7, 32'sd14, 32'sd15, -32'sd10, f, s, fc, r0, r1, ob, to);
    checks++;
    if (to || f != 0 || s != 1) begin
      errors++;
      $display("FAIL tie_order: got %0d,%0d (timeout=%0d) expected 0,1", f, s, to);
    end
    checks++;
    if (fc != 0) begin
      errors++;
      $display("FAIL tie_first_edge: got cycle %0d expected 0", fc);
    end
    checks++;
    if (r0 !== -64'sd98 || r1 !== -64'sd150) begin
      errors++;
      $display("FAIL tie_results: got %0d,%0d expected -98,-150", $signed(r0), $signed(r1));
    end
    checks++;
    if (ob) begin
      errors++;
      $display("FAIL tie_owner: got owner not matching responder expected match");
    end
    last_served = 1;
  endtask

  task automatic test_corners();
    logic [31:0] ta[3];
    logic [31:0] tb[3];
    logic [63:0] te[3];
    int lat; logic [63:0] res; bit to, other;
    ta[0] = 32'h8000_0000; tb[0] = 32'd1;          te[0] = 64'hffff_ffff_8000_0000;
    ta[1] = 32'h7fff_ffff; tb[1] = 32'd2;          te[1] = 64'd4294967294;
    ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000;  te[2] = 64'd4611686018427387904;
    for (int i = 0; i < 3; i++) begin
      issue(i % 2, ta[i], tb[i], lat, res, to, other);
      checks++;
      if (to || lat != 33 || res !== te[i]) begin
        errors++;
        $display("FAIL corner_%0d: got %0d lat=%0d expected %0d lat=33", i, $signed(res), lat, $signed(te[i]));
      end
      last_served = bit'(i % 2);
    end
  endtask

  task automatic test_backpressure();
    int k, lat; bit bad, early; logic [63:0] held;
    bad = 0; early = 0; lat = 0;
    @(posedge clk); #1;
    set_req(1, 1'b1, -32'sd1234, 32'sd5678);
    rsp1_ready = 1'b0;
    #1;
    for (k = 0; k < 10 && !req1_ready; k++) begin @(posedge clk); #2; end
    @(posedge clk); #1;
    set_req(1, 1'b0, $urandom, $urandom);
    set_req(0, 1'b1, 32'sd7, -32'sd3);
    for (k = 0; k < 60 && !rsp1_valid; k++) begin
      @(posedge clk); #1;
      if (req0_ready) early = 1;
    end
    held = rsp1_result;
    checks++;
    if (held !== -64'sd7006652) begin
      errors++;
      $display("FAIL bp_result: got %0d expected -7006652", $signed(held));
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (rsp1_result !== -64'sd7006652 || !rsp1_valid || !busy) bad = 1;
      if (req0_ready) early = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got result/valid/busy disturbed expected stable");
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL bp_early_accept: got req0_ready high expected low before handshake");
    end
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    #1;
    checks++;
    if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rsp1_valid=%b req0_ready=%b expected 0 1", rsp1_valid, req0_ready);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, $urandom, $urandom);
    rsp0_ready = 1'b1;
    for (lat = 0; lat < 60 && !rsp0_valid; ) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 33 || rsp0_result !== -64'sd21) begin
      errors++;
      $display("FAIL bp_followup: got %0d lat=%0d expected -21 lat=33", $signed(rsp0_result), lat);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    last_served = 0;
  endtask

  task automatic test_reset_mid_run();
    int k, lat; logic [63:0] res; bit to, other, stale, held_bad;
    stale = 0; held_bad = 0;
    @(posedge clk); #1;
    set_req(0, 1'b1, $urandom, $urandom);
    rsp0_ready = 1'b1;
    #1;
    for (k = 0; k < 10 && !req0_ready; k++) begin @(posedge clk); #2; end
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, owner} !== 6'b0 ||
        {rsp0_result, rsp1_result} !== 128'b0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got ctrl=%b res=%h/%h expected all 0",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, owner}, rsp0_result, rsp1_result);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (busy || rsp0_valid || rsp1_valid) held_bad = 1;
    end
    rst_n = 1'b1;
    rsp0_ready = 1'b0;
    last_served = 1;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy || rsp0_valid || rsp1_valid) stale = 1;
    end
    checks++;
    if (stale || held_bad) begin
      errors++;
      $display("FAIL midrun_stale: got busy/rsp_valid after reset expected none");
    end
    issue(1, 32'd3, 32'd4, lat, res, to, other);
    checks++;
    if (to || lat != 33 || res !== 64'd12 || other) begin
      errors++;
      $display("FAIL midrun_new_req: got %0d lat=%0d expected 12 lat=33", $signed(res), lat);
    end
    last_served = 1;
  endtask

  task automatic test_random();
    logic [31:0] a0, b0, a1, b1;
    int lat, n, f, s, fc, ef; logic [63:0] res, r0, r1; bit to, other, ob;
    for (int it = 0; it < 16; it++) begin
      a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(0, 1);
        issue(n, a0, b0, lat, res, to, other);
        checks++;
        if (to || lat != 33 || res !== ref_mul(a0, b0) || other) begin
          errors++;
          $display("FAIL rand_single_%0d: req%0d got %h lat=%0d expected %h lat=33",
                   it, n, res, lat, ref_mul(a0, b0));
        end
        last_served = bit'(n);
      end else begin
        @(posedge clk); #1;
        ef = last_served ? 0 : 1;
        serve_pair(a0, b0, a1, b1, f, s, fc, r0, r1, ob, to);
        checks++;
        if (to || f != ef || s != 1 - ef || ob ||
            r0 !== ref_mul(a0, b0) || r1 !== ref_mul(a1, b1)) begin
          errors++;
          $display("FAIL rand_pair_%0d: got order %0d,%0d res %h,%h expected %0d,%0d res %h,%h",
                   it, f, s, r0, r1, ef, 1 - ef, ref_mul(a0, b0), ref_mul(a1, b1));
        end
        last_served = bit'(s);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    last_served = 1;
    test_reset();
    test_single();
    test_tie();
    test_corners();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width; the result is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have, for each requester n in {0,1}, port reqn_valid, input, 1 bit: operand pair offered.
REQ-005 SHALL have port reqn_ready, output, 1 bit: operand pair accepted this cycle when reqn_valid is also high.
REQ-006 SHALL have ports reqn_a and reqn_b, input, WIDTH bits each: signed two's-complement operands.
REQ-007 SHALL have port rspn_valid, output, 1 bit: result for requester n available.
REQ-008 SHALL have port rspn_ready, input, 1 bit: requester n consumes the result.
REQ-009 SHALL have port rspn_result, output, 2*WIDTH bits: signed product.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port owner, output, 1 bit: index of the requester currently being served.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE in one FSM.
REQ-013 In IDLE, SHALL assert reqn_ready only for the granted requester and keep the other ready low.
- The grant goes to the valid requester.
- If both requesters are valid, the grant goes to the requester not served last (round-robin pointer).
REQ-014 On an accept (valid and ready high on the same edge), SHALL perform three actions:
- latch both operands;
- set owner;
- flip the round-robin pointer to the requester just served, then go to RUN with cycle count 0.
REQ-015 RUN SHALL perform radix-2 shift-add on operand magnitudes, one multiplier bit per cycle, for exactly WIDTH cycles, then enter DONE.
REQ-016 Signed handling SHALL use these rules:
- the magnitude of the most negative value (-2^(WIDTH-1)) is represented exactly as an unsigned value;
- the final product is negated when the operand signs differ;
- the result SHALL equal the exact 2*WIDTH-bit two's-complement product for all operand pairs.
REQ-017 Latency SHALL be fixed: rspn_valid rises WIDTH+1 cycles after the accept edge, independent of operand values including zero.
REQ-018 In DONE, SHALL drive the following outputs:
- rsp[owner]_valid high;
- rsp[owner]_result stable;
- the other rsp_valid low;
- result held unchanged until rsp[owner]_ready is sampled high.
REQ-019 On the rsp handshake, SHALL return to IDLE and deassert rspn_valid on the next cycle.
- A new accept is possible in the cycle after the return to IDLE.
- No request is accepted in DONE or RUN.
REQ-020 SHALL ignore changes on reqn_a, reqn_b and reqn_valid outside IDLE, and SHALL never corrupt the in-flight operation.
REQ-021 SHALL keep all reqn_ready low outside IDLE.
REQ-022 SHALL not preempt an operation: a requester dropping valid after accept has no effect.

Reset
REQ-023 Asserting rst_n low SHALL asynchronously force the following, including mid-RUN or in DONE, with the in-flight operation discarded:
- state to IDLE;
- the round-robin pointer so that requester 0 wins the first tie;
- busy=0, owner=0, all rspn_valid=0, all rspn_result=0, all reqn_ready=0.
REQ-024 After rst_n deasserts, SHALL accept a request at the first rising edge in IDLE.

Structure
REQ-025 SHALL place the following in a shared package mult_pkg, used by this block and other multipliers:
- the WIDTH default;
- the FSM state typedef (IDLE/RUN/DONE).
REQ-026 SHALL instantiate one sub-module, shift_add_core, holding the following, with start/done strobes to the arbiter FSM:
- the magnitude registers;
- the partial-product accumulator;
- the cycle counter;
- the sign fix-up.
REQ-027 The arbiter SHALL own the grant logic, the round-robin pointer, operand/response steering and the FSM only.

Verification
REQ-028 Single request:
- Stimulus: req0 a=15, b=10 with rsp0_ready=1.
- Response: rsp0_valid exactly 33 cycles after accept, rsp0_result=150, rsp1_valid never high.
REQ-029 Tie and fairness:
- Stimulus: req0 (-7,14) and req1 (15,-10) both valid from reset.
- Response: req0 served first with result -98, then req1 with result -150, owner toggling 0->1.
REQ-030 Corner operands:
- Stimulus: a=-2147483648, b=1; then a=2147483647, b=2; then a=-2147483648, b=-2147483648.
- Response: -2147483648; 4294967294; 4611686018427387904.
REQ-031 Backpressure:
- Stimulus: req1 (-1234,5678) with rsp1_ready held low 5 cycles after rsp1_valid rises.
- Response: rsp1_result=-7006652 stable throughout, busy=1, req0 not accepted until after the rsp1 handshake.
REQ-032 Reset mid-run:
- Stimulus: assert rst_n low 10 cycles into RUN, release, then issue req1 (3,4).
- Response: all outputs 0 during reset, no stale response, and the new request yields 12 after 33 cycles.
